// File: rtl/avalon_sdot_master_if.sv
// Avalon-MM bus between the sdot master and the accelerator slave.
// The master drives the command side; the slave drives read data and the stall.
interface avalon_sdot_master_if;
  logic [7:0]  avm_address;
  logic [31:0] avm_writedata;
  logic        avm_write;
  logic        avm_read;
  logic        avm_chipselect;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_writedata, avm_write, avm_read, avm_chipselect,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_writedata, avm_write, avm_read, avm_chipselect,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avalon_sdot_master.sv
// Avalon-MM master for the sdot accelerator: streams X then Y into the slave,
// kicks it, polls the status register, then fetches and presents the FP32 result.
module avalon_sdot_master #(
  parameter int unsigned VEC_LEN     = 96,
  parameter int unsigned Y_BASE      = 96,
  parameter int unsigned START_ADDR  = 255,
  parameter int unsigned RESULT_ADDR = 254,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        done,
  output logic        error,
  avalon_sdot_master_if.master avm
);
  localparam int unsigned NWORDS = 2 * VEC_LEN;
  localparam int unsigned IDX_W  = $clog2(NWORDS) + 1;
  localparam int unsigned POLL_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [IDX_W-1:0]  NWORDS_W  = IDX_W'(NWORDS);
  localparam logic [POLL_W-1:0] TIMEOUT_W = POLL_W'(TIMEOUT);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [7:0]        START_A   = 8'(START_ADDR);
  localparam logic [7:0]        RESULT_A  = 8'(RESULT_ADDR);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_KICK, S_GAP, S_POLL, S_PCHK, S_FETCH, S_CAP, S_ERR
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [POLL_W-1:0] polls_q;
  logic [GAP_W-1:0]  gap_q;
  logic              busy_q, done_q, error_q;
  logic              wr_q, rd_q;
  logic [7:0]        addr_q;
  logic [31:0]       wdata_q, result_q;

  logic             accepted;
  logic [IDX_W-1:0] next_word;

  function automatic logic [7:0] word_addr(input logic [IDX_W-1:0] w);
    if (32'(w) < VEC_LEN) return 8'(w);
    return 8'(Y_BASE + 32'(w) - VEC_LEN);
  endfunction

  assign accepted  = (wr_q | rd_q) & ~avm.avm_waitrequest;
  // A write being accepted this cycle frees the command slot, so streaming runs one word per cycle.
  assign next_word = wr_q ? idx_q + IDX_W'(1) : idx_q;
  assign in_ready  = (state_q == S_LOAD) && (!wr_q || !avm.avm_waitrequest) && (next_word < NWORDS_W);

  // NOTE: state lives in one always_ff with non-blocking assignments only, so every
  // read in this block sees the pre-edge value and later assignments win cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      polls_q  <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (accepted) begin
        wr_q <= 1'b0;
        rd_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          // A start coinciding with the done/error pulse belongs to the job just finished.
          if (start && !done_q && !error_q) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        S_LOAD: begin
          if (wr_q && accepted) idx_q <= idx_q + IDX_W'(1);
          if (in_valid && in_ready) begin
            wr_q    <= 1'b1;
            addr_q  <= word_addr(next_word);
            wdata_q <= in_data;
          end else if (wr_q && accepted && idx_q == LAST_IDX) begin
            wr_q    <= 1'b1;
            addr_q  <= START_A;
            wdata_q <= 32'd1;
            state_q <= S_KICK;
          end
        end
        S_KICK: begin
          if (accepted) begin
            polls_q <= '0;
            if (POLL_GAP == 0) begin
              rd_q    <= 1'b1;
              addr_q  <= START_A;
              state_q <= S_POLL;
            end else begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            rd_q    <= 1'b1;
            addr_q  <= START_A;
            state_q <= S_POLL;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_POLL: begin
          if (accepted) begin
            if (polls_q != TIMEOUT_W) polls_q <= polls_q + POLL_W'(1);
            state_q <= S_PCHK;
          end
        end
        S_PCHK: begin
          if (avm.avm_readdata == '0) begin
            rd_q    <= 1'b1;
            addr_q  <= RESULT_A;
            state_q <= S_FETCH;
          end else if (polls_q == TIMEOUT_W) begin
            state_q <= S_ERR;
          end else if (POLL_GAP == 0) begin
            rd_q    <= 1'b1;
            addr_q  <= START_A;
            state_q <= S_POLL;
          end else begin
            gap_q   <= '0;
            state_q <= S_GAP;
          end
        end
        S_FETCH: begin
          if (accepted) state_q <= S_CAP;
        end
        S_CAP: begin
          result_q <= avm.avm_readdata;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        S_ERR: begin
          error_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

  assign avm.avm_address    = addr_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_chipselect = wr_q | rd_q;
endmodule

// File: tb/tb_avalon_sdot_master.sv
// Bench for avalon_sdot_master: a model slave plus a bus-transaction scoreboard,
// driven by one task per scenario.
module tb_avalon_sdot_master;
  localparam int N         = 96;
  localparam int NW        = 2 * N;
  localparam int TIMEOUT_P = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        busy, in_ready, done, error;
  logic [31:0] result;

  avalon_sdot_master_if bus ();

  avalon_sdot_master #(
    .VEC_LEN(N), .Y_BASE(96), .START_ADDR(255), .RESULT_ADDR(254),
    .POLL_GAP(0), .TIMEOUT(TIMEOUT_P)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .done(done), .error(error), .avm(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] words [NW];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          taken = 0;
  int          taken_base = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          stall_en = 1'b0;
  int          polls_needed = 1;
  int          slave_polls = 0;
  logic [31:0] slave_result = '0;
  bit          rd_pend = 1'b0;
  logic [7:0]  rd_addr = '0;
  bit          prev_stall = 1'b0;
  logic [41:0] prev_snap = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (reset_n && in_valid && in_ready) taken <= taken + 1;

  // Model slave: stalls at random when enabled, returns read data one cycle after acceptance.
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) begin
        rd_pend = 1'b0;
        if (rd_addr == 8'd255) begin
          slave_polls++;
          if (polls_needed > 0 && slave_polls >= polls_needed) bus.avm_readdata = '0;
          else bus.avm_readdata = slave_polls[0] ? 32'h0000_0001 : 32'h8000_0000;
        end else if (rd_addr == 8'd254) begin
          bus.avm_readdata = slave_result;
        end else begin
          bus.avm_readdata = 32'hBAD0_0000;
        end
      end else begin
        bus.avm_readdata = 32'hDEAD_BEEF;
      end
      bus.avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Bus monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    logic [41:0] snap;
    txn_t        e;
    logic        act;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      act  = bus.avm_write | bus.avm_read;
      snap = {bus.avm_write, bus.avm_read, bus.avm_address, bus.avm_writedata};
      n_cmp++;
      if (bus.avm_chipselect !== act) begin
        n_bad++;
        $display("FAIL chipselect: got %b, want %b", bus.avm_chipselect, act);
      end
      if (act) begin
        n_cmp++;
        if (bus.avm_write && bus.avm_read) begin
          n_bad++;
          $display("FAIL write_and_read: both strobes high at addr %0d", bus.avm_address);
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (snap !== prev_snap) begin
          n_bad++;
          $display("FAIL stall_stable: got %h, want %h", snap, prev_snap);
        end
      end
      if (act && !bus.avm_waitrequest) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_txn: wr=%b addr=%0d data=%h, none expected",
                   bus.avm_write, bus.avm_address, bus.avm_writedata);
        end else begin
          e = exp_q.pop_front();
          if (bus.avm_write !== e.wr || bus.avm_address !== e.addr ||
              (e.wr && bus.avm_writedata !== e.data)) begin
            n_bad++;
            $display("FAIL txn: got wr=%b addr=%0d data=%h, want wr=%b addr=%0d data=%h",
                     bus.avm_write, bus.avm_address, bus.avm_writedata, e.wr, e.addr, e.data);
          end
        end
        if (bus.avm_read) begin
          rd_pend = 1'b1;
          rd_addr = bus.avm_address;
        end
      end
      prev_stall = act && bus.avm_waitrequest;
      prev_snap  = snap;
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) err_cnt++;
      if (in_ready) begin
        n_cmp++;
        if (!busy || (taken - taken_base) >= NW) begin
          n_bad++;
          $display("FAIL in_ready_outside_load: busy=%b words_taken=%0d", busy, taken - taken_base);
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic fill_words(input bit random_data);
    for (int k = 0; k < NW; k++)
      words[k] = random_data ? $urandom : ((k < N) ? 32'h3F80_0000 : 32'h4000_0000);
  endtask

  task automatic push_job(input int polls, input bit fetch);
    txn_t t;
    for (int k = 0; k < NW; k++) begin
      t.wr   = 1'b1;
      t.addr = 8'((k < N) ? k : 96 + k - N);
      t.data = words[k];
      exp_q.push_back(t);
    end
    t.wr = 1'b1; t.addr = 8'd255; t.data = 32'd1;
    exp_q.push_back(t);
    for (int p = 0; p < polls; p++) begin
      t.wr = 1'b0; t.addr = 8'd255; t.data = '0;
      exp_q.push_back(t);
    end
    if (fetch) begin
      t.wr = 1'b0; t.addr = 8'd254; t.data = '0;
      exp_q.push_back(t);
    end
  endtask

  task automatic start_job(output int s_cyc);
    @(negedge clk);
    start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int gaps, input int limit);
    int fed = 0;
    int budget = 20000;
    while (fed < limit && budget > 0) begin
      in_valid = 1'b1;
      in_data  = words[fed];
      if (in_ready) begin
        fed++;
        @(negedge clk);
        if (gaps > 0 && fed < limit) begin
          in_valid = 1'b0;
          repeat (gaps) @(negedge clk);
        end
      end else begin
        @(negedge clk);
        budget--;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (fed !== limit) begin
      n_bad++;
      $display("FAIL feed_timeout: got %0d words taken, want %0d", fed, limit);
    end
  endtask

  task automatic wait_end(input int s_cyc, output int lat);
    int b = 0;
    while (!(done === 1'b1 || error === 1'b1) && b < 5000) begin
      @(negedge clk);
      b++;
    end
    lat = cyc - s_cyc - 1;
    n_cmp++;
    if (!(done === 1'b1 || error === 1'b1)) begin
      n_bad++;
      $display("FAIL end_timeout: got no done/error in %0d cycles, want one", b);
    end
  endtask

  task automatic run_job(input string name, input int gaps, input bit stall, input int npolls,
                         input logic [31:0] res, input bit expect_err, input int exp_lat,
                         input bit poke_start);
    logic [31:0] prev_res;
    int s_cyc, lat, d0, e0;
    prev_res     = result;
    stall_en     = stall;
    polls_needed = npolls;
    slave_result = res;
    slave_polls  = 0;
    push_job(expect_err ? TIMEOUT_P : npolls, !expect_err);
    d0 = done_cnt;
    e0 = err_cnt;
    taken_base = taken;
    start_job(s_cyc);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_after_start: got %b, want 1", name, busy);
    end
    fork
      feed(gaps, NW);
      begin
        if (poke_start) begin
          repeat (30) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    wait_end(s_cyc, lat);
    if (poke_start && done === 1'b1) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (lat !== exp_lat) begin
        n_bad++;
        $display("FAIL %s latency: got %0d, want %0d", name, lat, exp_lat);
      end
    end
    repeat (4) @(negedge clk);
    stall_en = 1'b0;
    n_cmp++;
    if (done_cnt - d0 !== (expect_err ? 0 : 1)) begin
      n_bad++;
      $display("FAIL %s done_pulses: got %0d, want %0d", name, done_cnt - d0, expect_err ? 0 : 1);
    end
    n_cmp++;
    if (err_cnt - e0 !== (expect_err ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s error_pulses: got %0d, want %0d", name, err_cnt - e0, expect_err ? 1 : 0);
    end
    n_cmp++;
    if (result !== (expect_err ? prev_res : res)) begin
      n_bad++;
      $display("FAIL %s result: got %h, want %h", name, result, expect_err ? prev_res : res);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_end: got %b, want 0", name, busy);
    end
    if (poke_start) repeat (20) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s leftover: got %0d pending txns busy=%b, want 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, in_ready, done, error} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, want 0000", {busy, in_ready, done, error});
    end
    n_cmp++;
    if ({bus.avm_write, bus.avm_read, bus.avm_chipselect} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b, want 000", {bus.avm_write, bus.avm_read, bus.avm_chipselect});
    end
    n_cmp++;
    if (bus.avm_address !== 8'h00 || bus.avm_writedata !== 32'h0 || result !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h result=%h, want all 0",
               bus.avm_address, bus.avm_writedata, result);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    fill_words(1'b0);
    run_job("basic", 0, 1'b0, 3, 32'h4340_0000, 1'b0, -1, 1'b0);
  endtask

  task automatic test_latency;
    fill_words(1'b0);
    run_job("latency", 0, 1'b0, 1, 32'h4340_0000, 1'b0, NW + 6, 1'b0);
  endtask

  task automatic test_stall;
    fill_words(1'b0);
    run_job("stall", 0, 1'b1, 3, 32'h4340_0000, 1'b0, -1, 1'b0);
  endtask

  task automatic test_in_gaps;
    fill_words(1'b1);
    run_job("in_gaps", 4, 1'b0, 2, 32'h3F00_1234, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout;
    fill_words(1'b0);
    run_job("timeout", 0, 1'b0, 0, 32'h1234_5678, 1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_job;
    int s_cyc, d0, e0;
    fill_words(1'b1);
    polls_needed = 1;
    slave_polls  = 0;
    push_job(1, 1'b1);
    d0 = done_cnt;
    e0 = err_cnt;
    taken_base = taken;
    start_job(s_cyc);
    feed(0, 50);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.avm_write, bus.avm_read, bus.avm_chipselect} !== 3'b000) begin
      n_bad++;
      $display("FAIL midreset_strobes: got %b, want 000", {bus.avm_write, bus.avm_read, bus.avm_chipselect});
    end
    n_cmp++;
    if ({busy, in_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL midreset_busy: got busy=%b in_ready=%b, want 0 0", busy, in_ready);
    end
    exp_q.delete();
    rd_pend = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0 || err_cnt != e0) begin
      n_bad++;
      $display("FAIL midreset_pulses: got done=%0d error=%0d extra, want 0 0",
               done_cnt - d0, err_cnt - e0);
    end
    run_job("after_reset", 0, 1'b0, 2, 32'h4120_0000, 1'b0, -1, 1'b0);
  endtask

  task automatic test_start_ignored;
    fill_words(1'b1);
    run_job("start_ignored", 0, 1'b0, 1, 32'h4049_0FDB, 1'b0, NW + 6, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_stall();
    test_in_gaps();
    test_timeout();
    test_reset_mid_job();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
